btn_mode_router: RTL
====================

# btn_mode_router

Parametrised successor to the watch/stopwatch button demux. It routes a bank of debounced button levels to one of `NUM_MODES` consumer channels and emits one-cycle press pulses and gated levels on that channel only. Held buttons auto-repeat; mode switches are glitch-free. It sits between the debouncers and the mode cores (watch, stopwatch, future modes). Inactive channels drive 0, never Z.

## Interface
- `NUM_MODES`, 2: number of consumer channels (≥2).
- `NUM_BTN`, 4: number of button inputs.
- `HOLD_CYC`, 100_000_000: cycles a single repeat-enabled button must be held before the first repeat pulse (≥2).
- `REPEAT_CYC`, 20_000_000: cycles between subsequent repeat pulses (≥1).
- `REPEAT_MASK`, 4'b1100: per-button auto-repeat enable, bit i = `btn_i[i]`.
- `MODE_W`, $clog2(NUM_MODES): width of the mode select (derived).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_i` in NUM_BTN: debounced, synchronous button levels.
- `mode_sel` in MODE_W: requested mode.
- `btn_pulse` out NUM_MODES*NUM_BTN: press/repeat pulses; channel m occupies bits [m*NUM_BTN +: NUM_BTN].
- `btn_level` out NUM_MODES*NUM_BTN: gated levels, same packing.
- `mode_o` out MODE_W: currently active mode.
- `busy` out 1: mode switch in progress.

## Operation
- FSM with two states, S_RUN and S_SWITCH. Reset state is S_RUN.
- Reset values: `active_mode`=0, all outputs 0, `btn_prev` = all ones, hold/repeat counters 0. Because `btn_prev` resets high, a button held through reset release gives no pulse until it is released and pressed again.
- S_RUN:
  - Rising edge (`btn_i[i]`=1, `btn_prev[i]`=0) → `btn_pulse[active_mode*NUM_BTN+i]`=1 for one cycle.
  - `btn_level` channel `active_mode` = `btn_i`.
  - All other channels are 0.
- Auto-repeat:
  - Armed only when exactly one button is high and its `REPEAT_MASK` bit is 1.
  - The counter clears whenever `btn_i` changes, when the armed condition is false, or in S_SWITCH.
  - With the press pulse at output cycle t, repeat pulses occur at t+HOLD_CYC, then every REPEAT_CYC cycles while the button stays held.
  - Counter widths are $clog2 of the larger of HOLD_CYC and REPEAT_CYC, plus 1. Counters never wrap.
- Mode switch:
  - In S_RUN, if the sampled `mode_sel` ≠ `active_mode` and `mode_sel` < NUM_MODES → go to S_SWITCH.
  - Out-of-range `mode_sel` is ignored; the current mode is held.
- S_SWITCH:
  - All `btn_pulse`/`btn_level` are 0 and `busy`=1.
  - Waits for `btn_i`==0 (all released).
  - On the edge where `btn_i`==0: `active_mode` ← current `mode_sel` (if in range, else unchanged), `btn_prev` ← 0, return to S_RUN.
  - If `mode_sel` returns to the old mode before release, the switch still completes and `active_mode` keeps its value.
- Simultaneous events:
  - Mode change and a button edge on the same edge: the switch wins, no pulse.
  - Multiple buttons rising together: each gets its own pulse; no repeat is armed (more than one high).
- `btn_prev` updates to `btn_i` every cycle in S_RUN.

## Timing
- All outputs are registered, with 1-cycle latency. If `btn_i[i]` rises before edge k, the pulse is high from edge k to edge k+1.
- `btn_level` follows `btn_i` with 1-cycle latency.
- `busy` and zeroed outputs take effect at the edge after `mode_sel` changes. `mode_o` updates at the release edge, and `busy` falls at that same edge.
- A pulse is exactly one cycle wide. A press/release shorter than one cycle is not guaranteed to be detected; inputs are debounced upstream.
- `rst_n` asserted mid-operation clears outputs immediately (asynchronous). Deassertion must be synchronised upstream.

## Test plan
Bench parameters: NUM_MODES=3, NUM_BTN=4, HOLD_CYC=8, REPEAT_CYC=3, REPEAT_MASK=4'b1100.

- Reset release with `btn_i`=4'b0001 held → no pulse. Release, then press again → a single pulse on bit 0 of channel 0, 1 cycle after the press.
- `mode_sel`=0, press `btn_i[3]` and hold 20 cycles → press pulse at t, repeats at t+8, t+11, t+14, t+17, t+20. Channel 1/2 bits stay 0 throughout.
- Hold `btn_i[0]` (not in mask) for 20 cycles → exactly one pulse. Hold `btn_i[2]` and `btn_i[3]` together → two pulses, no repeats.
- Hold `btn_i[1]` and set `mode_sel`=2 → `busy`=1 and all outputs 0 next cycle. Release → `mode_o`=2 and `busy`=0 at that edge. Next press of `btn_i[1]` → pulse on bit 9.
- `mode_sel`=3 (out of range) → no switch, `busy` stays 0, `mode_o` unchanged.
- Assert `rst_n`=0 during a repeat train → outputs 0 immediately. After release, `mode_o`=0.

Source files
------------

// File: rtl/btn_mode_router.sv
// rtl/btn_mode_router.sv - routes debounced buttons to one of NUM_MODES channels with press/repeat pulses
//
// Purpose:
//   Demultiplexes a bank of debounced button levels onto the currently active
//   consumer channel. The active channel receives one-cycle press pulses,
//   auto-repeat pulses for held repeat-enabled buttons, and gated levels.
//   Every other channel drives 0. Mode changes wait for all buttons to be
//   released so no consumer ever sees a partial press.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   btn_i      in   [NUM_BTN]            debounced synchronous button levels
//   mode_sel   in   [MODE_W]             requested mode
//   btn_pulse  out  [NUM_MODES*NUM_BTN]  press/repeat pulses, channel m at [m*NUM_BTN +: NUM_BTN]
//   btn_level  out  [NUM_MODES*NUM_BTN]  gated levels, same packing
//   mode_o     out  [MODE_W]             currently active mode
//   busy       out                       mode switch in progress

module btn_mode_router #(
    parameter int                 NUM_MODES   = 2,
    parameter int                 NUM_BTN     = 4,
    parameter int                 HOLD_CYC    = 100_000_000,
    parameter int                 REPEAT_CYC  = 20_000_000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = 4'b1100,
    parameter int                 MODE_W      = $clog2(NUM_MODES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_BTN-1:0]           btn_i,
    input  logic [MODE_W-1:0]            mode_sel,
    output logic [NUM_MODES*NUM_BTN-1:0] btn_pulse,
    output logic [NUM_MODES*NUM_BTN-1:0] btn_level,
    output logic [MODE_W-1:0]            mode_o,
    output logic                         busy
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_SWITCH = 1'b1;

    localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [MODE_W:0]  LP_NUM_MODES = (MODE_W+1)'(NUM_MODES);
    localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LP_REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    logic [0:0]                   r_state;
    logic [MODE_W-1:0]            r_active_mode;
    logic [NUM_BTN-1:0]           r_btn_prev;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_repeating;
    logic [NUM_MODES*NUM_BTN-1:0] r_pulse;
    logic [NUM_MODES*NUM_BTN-1:0] r_level;
    logic                         r_busy;

    logic                         w_in_range;
    logic                         w_req_switch;
    logic                         w_changed;
    logic                         w_armed;
    logic                         w_fire;
    logic [NUM_BTN-1:0]           w_rise;
    logic [NUM_BTN-1:0]           w_chan_pulse;
    logic [NUM_MODES*NUM_BTN-1:0] w_pulse_next;
    logic [NUM_MODES*NUM_BTN-1:0] w_level_next;

    assign w_in_range   = ({1'b0, mode_sel} < LP_NUM_MODES);
    assign w_req_switch = (mode_sel != r_active_mode) && w_in_range;
    assign w_changed    = (btn_i != r_btn_prev);
    assign w_rise       = btn_i & ~r_btn_prev;

    // Repeat only makes sense for a single, repeat-enabled button.
    assign w_armed = $onehot(btn_i) && ((btn_i & ~REPEAT_MASK) == '0);

    // r_cnt counts cycles since the press edge (hold phase) or since the last
    // repeat (repeat phase); it fires on the cycle it would reach the period.
    assign w_fire = w_armed && !w_changed &&
                    (r_repeating ? (r_cnt == LP_REP_LAST) : (r_cnt == LP_HOLD_LAST));

    assign w_chan_pulse = w_rise | (w_fire ? btn_i : '0);

    always_comb begin
        w_pulse_next = '0;
        w_level_next = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (r_active_mode == MODE_W'(m)) begin
                w_pulse_next[m*NUM_BTN +: NUM_BTN] = w_chan_pulse;
                w_level_next[m*NUM_BTN +: NUM_BTN] = btn_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_active_mode <= '0;
            // All-ones so a button held through reset release gives no pulse.
            r_btn_prev    <= '1;
            r_cnt         <= '0;
            r_repeating   <= 1'b0;
            r_pulse       <= '0;
            r_level       <= '0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_btn_prev <= btn_i;
                    if (w_req_switch) begin
                        // Switch wins over any same-cycle button edge.
                        r_state     <= S_SWITCH;
                        r_busy      <= 1'b1;
                        r_pulse     <= '0;
                        r_level     <= '0;
                        r_cnt       <= '0;
                        r_repeating <= 1'b0;
                    end else begin
                        r_pulse <= w_pulse_next;
                        r_level <= w_level_next;
                        if (!w_armed || w_changed) begin
                            r_cnt       <= '0;
                            r_repeating <= 1'b0;
                        end else if (w_fire) begin
                            r_cnt       <= '0;
                            r_repeating <= 1'b1;
                        end else if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_pulse     <= '0;
                    r_level     <= '0;
                    r_cnt       <= '0;
                    r_repeating <= 1'b0;
                    r_busy      <= 1'b1;
                    if (btn_i == '0) begin
                        // mode_sel may have moved again while waiting; take the
                        // latest in-range request, or keep the old mode.
                        if (w_in_range) begin
                            r_active_mode <= mode_sel;
                        end
                        r_btn_prev <= '0;
                        r_state    <= S_RUN;
                        r_busy     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign btn_pulse = r_pulse;
    assign btn_level = r_level;
    assign mode_o    = r_active_mode;
    assign busy      = r_busy;

endmodule
